// File: rtl/inst_fetcher_pkg.sv
// Fetch-path types and RISC-V opcode constants shared with the decoder,
// plus the static next-PC predecode used on every returned instruction word.
package inst_fetcher_pkg;

    typedef logic [31:0] inst_type;
    typedef logic [31:0] addr_type;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;

    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_JAL = 7'b1101111;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_BR  = 7'b1100011;

    typedef struct packed {
        inst_type inst;
        addr_type pc;
        addr_type pred_pc;
    } fetch_entry_t;

    // JAL always taken, backward branches taken, everything else (JALR too) falls through.
    function automatic addr_type predict_next_pc(input inst_type word, input addr_type pc);
        addr_type                      offset;
        logic [OPCODE_MSB:OPCODE_LSB]  opcode;
        opcode = word[OPCODE_MSB:OPCODE_LSB];
        if (opcode == OPCODE_JAL) begin
            offset = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
        end else if ((opcode == OPCODE_BR) && word[31]) begin
            offset = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
        end else begin
            offset = 32'd4;
        end
        return pc + offset;
    endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular FIFO of fetched {inst, pc, pred_pc} entries with an occupancy count;
// head reads as all-zero while empty.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           push_entry,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW + 1)'(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   count_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign pop_ok_s  = pop && (count_r != '0);
    assign push_ok_s = push && ((count_r != DEPTH_L) || pop_ok_s);
    assign count     = count_r;

    // Pointer, count and storage update; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + (PW + 1)'(1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_r <= count_r - (PW + 1)'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Head view, forced to zero while the queue is empty.
    always_comb begin
        head = '0;
        if (count_r != '0) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: owns the PC, keeps one icache request in flight,
// predecodes returned words for a static next PC and buffers them for the decoder.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int       QUEUE_DEPTH = 16,
    parameter addr_type RESET_PC    = 32'h0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy,
    output logic     icache_req_valid,
    output addr_type icache_req_addr,
    input  logic     icache_resp_valid,
    input  inst_type icache_resp_inst,
    output logic     inst_valid,
    output inst_type inst,
    output addr_type inst_pc,
    output addr_type inst_pred_pc,
    input  logic     inst_ready,
    input  logic     flush,
    input  addr_type flush_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_L    = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_L = CW'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t  state_r;
    addr_type      pc_r;
    addr_type      req_addr_r;
    logic          req_valid_r;
    addr_type      pred_s;
    logic          clear_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;

    assign pred_s       = predict_next_pc(icache_resp_inst, pc_r);
    assign clear_s      = rdy && flush;
    assign push_s       = rdy && icache_resp_valid && !flush && (state_r == ST_WAIT);
    assign inst_valid   = (count_s != '0) && !clear_s;
    assign pop_s        = rdy && inst_valid && inst_ready;
    assign push_entry_s = {icache_resp_inst, pc_r, pred_s};

    assign icache_req_valid = req_valid_r;
    assign icache_req_addr  = req_addr_r;
    assign inst             = head_s.inst;
    assign inst_pc          = head_s.pc;
    assign inst_pred_pc     = head_s.pred_pc;

    inst_queue #(
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .clear      (clear_s),
        .push_entry (push_entry_s),
        .count      (count_s),
        .head       (head_s)
    );

    // Fetch FSM: a request is only issued when its FIFO slot is guaranteed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            req_valid_r <= 1'b0;
            req_addr_r  <= 32'h0;
        end else if (rdy) begin
            if (flush) begin
                pc_r <= flush_pc;
                case (state_r)
                    ST_WAIT, ST_DISCARD: begin
                        if (icache_resp_valid) begin
                            req_valid_r <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r     <= ST_DISCARD;
                        end
                    end
                    default: begin
                        req_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (count_s < DEPTH_L) begin
                            req_valid_r <= 1'b1;
                            req_addr_r  <= pc_r;
                            state_r     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (icache_resp_valid) begin
                            pc_r <= pred_s;
                            // Re-issue only if a slot remains after this push.
                            if (count_s < DEPTH_M1_L) begin
                                req_addr_r <= pred_s;
                            end else begin
                                req_valid_r <= 1'b0;
                                state_r     <= ST_IDLE;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (icache_resp_valid) begin
                            req_valid_r <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end
                    default: begin
                        req_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: icache model, program-order walk reference
// and a scoreboard that checks every instruction the decoder accepts.
module tb_inst_fetcher;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pred_pc;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_pc;

    always #5 clk = ~clk;

    inst_fetcher #(
        .QUEUE_DEPTH       (DEPTH),
        .RESET_PC          (32'h0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rdy               (rdy),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_inst  (icache_resp_inst),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .inst_pred_pc      (inst_pred_pc),
        .inst_ready        (inst_ready),
        .flush             (flush),
        .flush_pc          (flush_pc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] walk_pc = 32'h0;
    int          vectors = 0;
    int          miscompares = 0;

    int          rdy_pct = 100;
    int          ready_pct = 100;
    int          ic_min = 0;
    int          ic_max = 1;
    bit          flush_next = 1'b0;
    bit          flush_on_resp = 1'b0;
    bit          flush_fired = 1'b0;
    logic [31:0] flush_target = 32'h0;

    bit          ic_busy = 1'b0;
    logic [31:0] ic_addr = 32'h0;
    int          ic_cnt = 0;
    int          ic_epoch_req = 0;
    int          epoch = 0;
    int          fresh_cnt = 0;
    bit          first_seen = 1'b0;
    logic [31:0] first_addr = 32'h0;

    // Program image: a few fixed words, the rest a deterministic hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a < 32'h20) return 32'h00100093;
        if (a == 32'h20) return 32'h0100006F;
        if ((a >= 32'h24) && (a < 32'h40)) return 32'h00100093;
        if (a == 32'h40) return 32'hFE000EE3;
        if (a == 32'h100) return 32'h00000463;
        h = (a ^ 32'h5bd1e995) * 32'h9E3779B1;
        h = h ^ (h >> 13);
        case (h[9:8])
            2'd0:    return {h[31:22], 1'b0, h[20:7], 7'b1101111};
            2'd1:    return {h[31:9], 1'b0, h[7], 7'b1100011};
            2'd2:    return {h[31:7], 7'b1100111};
            default: return {h[31:7], 7'b0010011};
        endcase
    endfunction

    // Next PC from the prediction rules, using plain integer arithmetic on the fields.
    function automatic logic [31:0] ref_next(input logic [31:0] w, input logic [31:0] pc);
        int off;
        if (w[6:0] == 7'h6F)
            off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - int'(w[31]) * (1 << 20);
        else if ((w[6:0] == 7'h63) && w[31])
            off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
        else
            off = 4;
        return pc + 32'(off);
    endfunction

    function automatic void extend_walk();
        exp_t e;
        e.inst  = mem_word(walk_pc);
        e.pc    = walk_pc;
        e.pred  = ref_next(e.inst, walk_pc);
        walk_pc = e.pred;
        exp_q.push_back(e);
    endfunction

    function automatic void restart_walk(input logic [31:0] start);
        exp_q.delete();
        walk_pc = start;
        for (int i = 0; i < 8; i++) extend_walk();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: run enable, decoder ready, icache model and flush.
    task automatic step();
        bit resp;
        @(negedge clk);
        resp              = 1'b0;
        rdy               = ($urandom_range(99, 0) < rdy_pct);
        inst_ready        = ($urandom_range(99, 0) < ready_pct);
        flush             = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_inst  = $urandom();
        if (rdy) begin
            if (ic_busy) begin
                check("req_held_valid", 32'(icache_req_valid), 32'd1);
                check("req_held_addr", icache_req_addr, ic_addr);
            end else if (icache_req_valid) begin
                ic_busy      = 1'b1;
                ic_addr      = icache_req_addr;
                ic_cnt       = $urandom_range(ic_max, ic_min);
                ic_epoch_req = epoch;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_addr = icache_req_addr;
                end
            end
            if (ic_busy) begin
                if (ic_cnt == 0) begin
                    resp              = 1'b1;
                    ic_busy           = 1'b0;
                    icache_resp_valid = 1'b1;
                    icache_resp_inst  = mem_word(ic_addr);
                end else begin
                    ic_cnt--;
                end
            end
            if (flush_on_resp && resp) begin
                flush_on_resp = 1'b0;
                flush_fired   = 1'b1;
                flush         = 1'b1;
            end
            if (flush_next) begin
                flush_next = 1'b0;
                flush      = 1'b1;
            end
            flush_pc = flush_target;
            if (resp && !flush && (ic_epoch_req == epoch)) fresh_cnt++;
            if (flush) begin
                epoch++;
                fresh_cnt  = 0;
                first_seen = 1'b0;
                restart_walk(flush_target);
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard: every accepted head must be the next word on the predicted path.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (rdy && flush) begin
                check("flush_inst_valid", 32'(inst_valid), 32'd0);
            end else if (!inst_valid) begin
                check("empty_inst", inst, 32'h0);
                check("empty_inst_pc", inst_pc, 32'h0);
                check("empty_pred_pc", inst_pred_pc, 32'h0);
            end else if (rdy && inst_ready) begin
                if (exp_q.size() == 0) extend_walk();
                e = exp_q.pop_front();
                check("head_inst", inst, e.inst);
                check("head_pc", inst_pc, e.pc);
                check("head_pred_pc", inst_pred_pc, e.pred);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        s_rv, s_iv;
        logic [31:0] s_ra, s_in, s_pc, s_pp;

        rst_n = 1'b0; rdy = 1'b0; inst_ready = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        icache_resp_valid = 1'b0; icache_resp_inst = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_valid", 32'(icache_req_valid), 32'd0);
        check("reset_req_addr", icache_req_addr, 32'h0);
        check("reset_inst_valid", 32'(inst_valid), 32'd0);
        check("reset_inst", inst, 32'h0);
        check("reset_inst_pc", inst_pc, 32'h0);
        check("reset_pred_pc", inst_pred_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First fetch from RESET_PC, icache answers after a fixed delay.
        rdy_pct = 100; ready_pct = 100; ic_min = 2; ic_max = 2;
        for (int i = 0; i < 10 && !icache_req_valid; i++) step();
        check("first_req_valid", 32'(icache_req_valid), 32'd1);
        check("first_req_addr", icache_req_addr, 32'h0);
        for (int i = 0; i < 10 && fresh_cnt == 0; i++) step();
        step();
        check("reissue_valid", 32'(icache_req_valid), 32'd1);
        check("reissue_addr", icache_req_addr, 32'h4);
        check("first_inst_valid", 32'(inst_valid), 32'd1);
        check("first_inst", inst, 32'h00100093);
        check("first_inst_pc", inst_pc, 32'h0);
        check("first_pred_pc", inst_pred_pc, 32'h4);

        // Straight line, JAL at 0x20 and backward branch loop at 0x40.
        ic_min = 0; ic_max = 2;
        run(60);

        // Flush while a request is outstanding: stale word must never surface.
        ic_min = 3; ic_max = 4; ready_pct = 50;
        for (int i = 0; i < 20 && !(ic_busy && ic_cnt >= 2); i++) step();
        check("wait_outstanding", 32'(ic_busy), 32'd1);
        flush_target = 32'h100; flush_next = 1'b1;
        step();
        step();
        check("flush_empty", 32'(inst_valid), 32'd0);
        run(25);
        check("flush_first_seen", 32'(first_seen), 32'd1);
        check("flush_first_addr", first_addr, 32'h100);

        // Fill with the decoder stalled: exactly DEPTH pushes, then no issue.
        ic_min = 0; ic_max = 1; ready_pct = 0;
        flush_target = 32'h200; flush_next = 1'b1;
        step();
        run(80);
        check("full_push_count", 32'(fresh_cnt), 32'(DEPTH));
        check("full_no_req", 32'(icache_req_valid), 32'd0);
        ready_pct = 100;
        step();
        ready_pct = 0;
        run(20);
        check("one_pop_one_fetch", 32'(fresh_cnt), 32'(DEPTH + 1));
        check("refull_no_req", 32'(icache_req_valid), 32'd0);

        // Flush coinciding with a response and a pop.
        ready_pct = 100; flush_target = 32'h300; flush_on_resp = 1'b1;
        for (int i = 0; i < 20 && !flush_fired; i++) step();
        flush_on_resp = 1'b0;
        check("coinc_fired", 32'(flush_fired), 32'd1);
        check("coinc_inst_valid", 32'(inst_valid), 32'd0);
        step();
        check("coinc_idle_no_req", 32'(icache_req_valid), 32'd0);
        step();
        check("coinc_req_valid", 32'(icache_req_valid), 32'd1);
        check("coinc_req_addr", icache_req_addr, 32'h300);

        // Stall with some words buffered and a request outstanding: nothing moves.
        ready_pct = 30;
        run(6);
        rdy_pct = 0; ready_pct = 50;
        step();
        s_rv = icache_req_valid; s_ra = icache_req_addr; s_iv = inst_valid;
        s_in = inst; s_pc = inst_pc; s_pp = inst_pred_pc;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_req_valid", 32'(icache_req_valid), 32'(s_rv));
            check("stall_req_addr", icache_req_addr, s_ra);
            check("stall_inst_valid", 32'(inst_valid), 32'(s_iv));
            check("stall_inst", inst, s_in);
            check("stall_inst_pc", inst_pc, s_pc);
            check("stall_pred_pc", inst_pred_pc, s_pp);
        end

        // Random traffic with occasional redirects.
        rdy_pct = 85; ready_pct = 60; ic_min = 0; ic_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (!flush_next && ($urandom_range(99, 0) < 2)) begin
                flush_target = ($urandom_range(3, 0) == 0) ? 32'h0 : ($urandom() & 32'hFFFF_FFFC);
                flush_next   = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
